// File: rtl/opb_register_simulink2ppc.sv
// OPB slave register carrying one 32-bit word from fabric logic to the PowerPC.
// DATA returns the latest captured word. STATUS returns an update counter plus
// overrun and fresh flags, so software can poll without losing or re-reading samples.
//
// state | meaning
// IDLE  | waiting for an address hit on the OPB
// ACK   | one-cycle transfer acknowledge, read data driven on Sl_DBus
module opb_register_simulink2ppc #(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic                    Sl_xferAck,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  input  logic [31:0]             user_data_in,
  input  logic                    user_data_valid
);

  typedef enum logic {IDLE, ACK} state_t;

  state_t      state;
  logic        acc_read;
  logic        acc_status;
  logic        acc_clr;
  logic [31:0] shadow;
  logic [31:0] pending;
  logic        pending_vld;
  logic        fresh;
  logic        overrun;
  logic [15:0] count;

  logic [31:0] addr_off;
  logic        hit;
  logic        data_rd_ack;
  logic [31:0] rdata;
  logic        unused_ok;

  // Offset from the window base; an address below the base wraps high and misses.
  assign addr_off    = OPB_ABus - C_BASEADDR;
  assign hit         = OPB_select && (addr_off <= (C_HIGHADDR - C_BASEADDR));
  assign data_rd_ack = (state == ACK) && acc_read && !acc_status;

  assign rdata      = acc_status ? {count, 14'b0, overrun, fresh} : shadow;
  assign Sl_xferAck = (state == ACK);
  assign Sl_DBus    = ((state == ACK) && acc_read) ? rdata : '0;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign unused_ok = &{1'b0, |C_FAMILY, OPB_seqAddr, OPB_BE[0:2], OPB_DBus};

  // Bus FSM plus fabric capture; a capture arriving while a DATA read is being
  // acked is parked in pending so the read sees a stable word.
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      state       <= IDLE;
      acc_read    <= 1'b0;
      acc_status  <= 1'b0;
      acc_clr     <= 1'b0;
      shadow      <= '0;
      pending     <= '0;
      pending_vld <= 1'b0;
      fresh       <= 1'b0;
      overrun     <= 1'b0;
      count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state      <= ACK;
            acc_read   <= OPB_RNW;
            acc_status <= OPB_ABus[29];
            acc_clr    <= !OPB_RNW && OPB_ABus[29] && OPB_BE[3] && OPB_DBus[30];
          end
        end
        default: state <= IDLE;
      endcase

      // Clear first so a same-cycle overrun-setting capture below wins.
      if ((state == ACK) && acc_clr)
        overrun <= 1'b0;

      if (data_rd_ack) begin
        fresh <= 1'b0;
        if (user_data_valid) begin
          pending     <= user_data_in;
          pending_vld <= 1'b1;
        end
      end else if (pending_vld) begin
        pending_vld <= 1'b0;
        fresh       <= 1'b1;
        if (user_data_valid) begin
          shadow  <= user_data_in;
          count   <= count + 16'd2;
          overrun <= 1'b1;
        end else begin
          shadow <= pending;
          count  <= count + 16'd1;
        end
      end else if (user_data_valid) begin
        shadow <= user_data_in;
        fresh  <= 1'b1;
        count  <= count + 16'd1;
        if (fresh)
          overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Bench for opb_register_simulink2ppc: a transaction-level model predicts
// xferAck and read data every cycle, directed sequences pin literal values.
module tb_opb_register_simulink2ppc;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] HIGH = 32'h0000_00FF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] abus = '0;
  logic [3:0]  be = '0;
  logic [31:0] dbus = '0;
  logic        rnw = 1'b0;
  logic        sel = 1'b0;
  logic        seq = 1'b0;
  logic [31:0] din = '0;
  logic        valid = 1'b0;

  logic [31:0] sl_dbus;
  logic        sl_erracks, sl_retry, sl_toutsup, sl_xferack;

  int checks = 0;
  int errors = 0;

  opb_register_simulink2ppc #(.C_BASEADDR(BASE), .C_HIGHADDR(HIGH)) dut (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n),
    .Sl_DBus(sl_dbus), .Sl_errAck(sl_erracks), .Sl_retry(sl_retry),
    .Sl_toutSup(sl_toutsup), .Sl_xferAck(sl_xferack),
    .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus), .OPB_RNW(rnw),
    .OPB_select(sel), .OPB_seqAddr(seq),
    .user_data_in(din), .user_data_valid(valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Register-level model: software-visible state plus the transfer being acked.
  logic [31:0] m_shadow, m_pend;
  logic [15:0] m_count;
  bit          m_pend_v, m_fresh, m_ovr;
  bit          m_ack, m_rnw, m_stat, m_clr;
  bit          exp_ack;
  logic [31:0] exp_dbus = '0;
  bit          started = 1'b0;

  task automatic model_step();
    bit consumed;
    if (!rst_n) begin
      m_shadow = '0; m_pend = '0; m_count = '0;
      m_pend_v = 0; m_fresh = 0; m_ovr = 0;
      m_ack = 0; m_rnw = 0; m_stat = 0; m_clr = 0;
    end else begin
      consumed = m_ack && m_rnw && !m_stat;
      if (m_ack && m_clr) m_ovr = 0;
      if (consumed) begin
        m_fresh = 0;
        if (valid) begin m_pend = din; m_pend_v = 1; end
      end else if (m_pend_v) begin
        m_pend_v = 0;
        m_fresh  = 1;
        if (valid) begin m_shadow = din; m_count += 16'd2; m_ovr = 1; end
        else begin m_shadow = m_pend; m_count += 16'd1; end
      end else if (valid) begin
        if (m_fresh) m_ovr = 1;
        m_shadow = din; m_fresh = 1; m_count += 16'd1;
      end
      if (!m_ack && sel && ((abus - BASE) <= (HIGH - BASE))) begin
        m_ack  = 1;
        m_rnw  = rnw;
        m_stat = abus[2];
        m_clr  = !rnw && abus[2] && be[0] && dbus[1];
      end else begin
        m_ack = 0;
      end
    end
    exp_ack  = m_ack;
    exp_dbus = (m_ack && m_rnw) ? (m_stat ? {m_count, 14'b0, m_ovr, m_fresh} : m_shadow) : 32'h0;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    started = 1'b1;
  end

  // Per-cycle comparison against the model, half a cycle after each edge.
  initial forever begin
    @(negedge clk);
    if (started) begin
      check("xferack", {31'b0, sl_xferack}, {31'b0, exp_ack});
      check("dbus", sl_dbus, exp_dbus);
    end
  end

  task automatic xfer(input logic [31:0] a, input bit r, input logic [31:0] wd,
                      input logic [3:0] b, output logic [31:0] rd, output int lat);
    @(negedge clk);
    sel = 1'b1; abus = a; rnw = r; dbus = wd; be = b;
    lat = 0; rd = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (sl_xferack) begin rd = sl_dbus; lat = i; break; end
    end
    sel = 1'b0; dbus = '0; be = '0;
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL xfer_timeout addr %h: no ack, required within 8 cycles", a);
    end
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd; int lat;
    xfer(a, 1'b1, 32'h0, 4'h0, rd, lat);
    check(name, rd, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b);
    logic [31:0] rd; int lat;
    xfer(a, 1'b0, wd, b, rd, lat);
  endtask

  task automatic capture(input logic [31:0] w);
    @(negedge clk); valid = 1'b1; din = w;
    @(negedge clk); valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // DATA read with captures injected in the ACK cycle and optionally the next.
  task automatic read_with_capture(input logic [31:0] w_ack, input bit second,
                                   input logic [31:0] w_next, input logic [31:0] exp_rd);
    logic [31:0] rd;
    @(negedge clk); sel = 1'b1; abus = 32'h0; rnw = 1'b1;
    @(negedge clk);
    check("sim_ack", {31'b0, sl_xferack}, 32'h1);
    rd = sl_dbus; sel = 1'b0; valid = 1'b1; din = w_ack;
    @(negedge clk);
    if (second) begin din = w_next; @(negedge clk); end
    valid = 1'b0;
    check("sim_rd", rd, exp_rd);
  endtask

  initial begin
    logic [31:0] rd;
    int lat;

    // Reset
    repeat (3) @(negedge clk);
    check("rst_ack", {31'b0, sl_xferack}, 32'h0);
    check("rst_dbus", sl_dbus, 32'h0);
    check("tieoffs", {29'b0, sl_erracks, sl_retry, sl_toutsup}, 32'h0);
    rst_n = 1'b1;
    rd_chk("rst_status", 32'h4, 32'h0000_0000);

    // Capture and read
    capture(32'hDEAD_BEEF);
    rd_chk("cap_status", 32'h4, 32'h0001_0001);
    xfer(32'h0, 1'b1, 32'h0, 4'h0, rd, lat);
    check("cap_data", rd, 32'hDEAD_BEEF);
    check("cap_latency", lat, 1);
    rd_chk("cap_status2", 32'h4, 32'h0001_0000);

    // Overrun
    do_reset();
    capture(32'h1);
    capture(32'h2);
    rd_chk("ovr_status", 32'h4, 32'h0002_0003);
    rd_chk("ovr_data", 32'h0, 32'h0000_0002);
    wr(32'h4, 32'h0000_0002, 4'b0001);
    rd_chk("ovr_clear", 32'h4, 32'h0002_0000);

    // Capture racing a DATA read
    capture(32'hA);
    read_with_capture(32'hB, 1'b0, 32'h0, 32'hA);
    rd_chk("sim_status", 32'h4, 32'h0004_0001);
    rd_chk("sim_data", 32'h0, 32'h0000_000B);
    read_with_capture(32'hC, 1'b1, 32'hD, 32'hB);
    rd_chk("sim2_status", 32'h4, 32'h0006_0003);
    rd_chk("sim2_data", 32'h0, 32'h0000_000D);

    // DATA write ignored, aliasing through the window
    wr(32'h0, 32'hFFFF_FFFF, 4'hF);
    rd_chk("alias_status", 32'hC, 32'h0006_0002);
    rd_chk("alias_data", 32'h8, 32'h0000_000D);

    // Counter wrap
    do_reset();
    @(negedge clk); valid = 1'b1;
    repeat (65536) begin din = $urandom; @(negedge clk); end
    valid = 1'b0;
    rd_chk("wrap_status", 32'h4, 32'h0000_0003);

    // Address miss just past the window
    @(negedge clk); sel = 1'b1; abus = HIGH + 32'd5 - 32'd1; rnw = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("miss_ack", {31'b0, sl_xferack}, 32'h0);
      check("miss_dbus", sl_dbus, 32'h0);
    end
    sel = 1'b0;

    // Back-to-back with select held
    @(negedge clk); sel = 1'b1; abus = 32'h0; rnw = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("b2b_ack", {31'b0, sl_xferack}, {31'b0, (k % 2) == 0});
    end
    sel = 1'b0;

    // Reset during ACK
    capture(32'h1234_5678);
    @(negedge clk); sel = 1'b1; abus = 32'h0; rnw = 1'b1;
    @(negedge clk);
    check("rstack_pre", {31'b0, sl_xferack}, 32'h1);
    rst_n = 1'b0; sel = 1'b0;
    @(negedge clk);
    check("rstack_ack", {31'b0, sl_xferack}, 32'h0);
    check("rstack_dbus", sl_dbus, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    rd_chk("rstack_status", 32'h4, 32'h0000_0000);
    rd_chk("rstack_data", 32'h0, 32'h0000_0000);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
